dlsc_pcie_s6_inbound_read_cpl: RTL and testbench

// - Completer-side splitter. Takes one accepted inbound PCIe memory-read request header and emits completion headers.
// - Each completion header carries: DW address, DW length, byte count, lower address, tag, requester ID and a last flag.
// - Completion lengths honour max_payload_size, capped by MAX_SIZE.
// - Every completion except the last ends on a naturally aligned payload boundary.
// - Sits between the RX TLP decoder and the completion-data fetch/TX TLP builder.

---
 rtl/dlsc_pcie_s6_pkg.sv | 47 ++++
 rtl/dlsc_pcie_s6_cpl_bytecount.sv | 29 ++
 rtl/dlsc_pcie_s6_inbound_read_cpl.sv | 150 +++++++++++++++
 tb/tb_dlsc_pcie_s6_inbound_read_cpl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared PCIe S6 helpers: MPS encodings, MPS-to-DW conversion and byte-enable zero counts.
package dlsc_pcie_s6_pkg;

  localparam logic [2:0] MPS_128  = 3'b000;
  localparam logic [2:0] MPS_256  = 3'b001;
  localparam logic [2:0] MPS_512  = 3'b010;
  localparam logic [2:0] MPS_1024 = 3'b011;
  localparam logic [2:0] MPS_2048 = 3'b100;
  localparam logic [2:0] MPS_4096 = 3'b101;

  localparam int unsigned DW_CNT_W = 11;

  // Reserved encodings fall back to 128 B; result is capped at max_size_dw.
  function automatic logic [DW_CNT_W-1:0] mps_to_dw(input logic [2:0] code,
                                                    input int unsigned max_size_dw);
    logic [DW_CNT_W-1:0] dw;
    case (code)
      MPS_256:  dw = 11'd64;
      MPS_512:  dw = 11'd128;
      MPS_1024: dw = 11'd256;
      MPS_2048: dw = 11'd512;
      MPS_4096: dw = 11'd1024;
      default:  dw = 11'd32;
    endcase
    if (32'(dw) > max_size_dw) dw = 11'(max_size_dw);
    return dw;
  endfunction

  // Number of disabled bytes below the lowest enabled byte.
  function automatic logic [1:0] be_lead_zeros(input logic [3:0] be);
    if (be[0])      return 2'd0;
    else if (be[1]) return 2'd1;
    else if (be[2]) return 2'd2;
    else if (be[3]) return 2'd3;
    else            return 2'd0;
  endfunction

  // Number of disabled bytes above the highest enabled byte.
  function automatic logic [1:0] be_trail_zeros(input logic [3:0] be);
    if (be[3])      return 2'd0;
    else if (be[2]) return 2'd1;
    else if (be[1]) return 2'd2;
    else if (be[0]) return 2'd3;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_cpl_bytecount.sv
// Total byte count and first-DW offset of a read request from its DW length and byte enables.
module dlsc_pcie_s6_cpl_bytecount
  import dlsc_pcie_s6_pkg::*;
(
  input  logic [9:0]  i_len,
  input  logic [3:0]  i_be_first,
  input  logic [3:0]  i_be_last,
  output logic [12:0] o_total_c,
  output logic [1:0]  o_fz_c
);

  logic [10:0] w_len_dw;

  always_comb begin
    w_len_dw  = (i_len == 10'd0) ? 11'd1024 : {1'b0, i_len};
    o_fz_c    = be_lead_zeros(i_be_first);
    o_total_c = {w_len_dw, 2'b00} - 13'(o_fz_c) - 13'(be_trail_zeros(i_be_last));
    if (w_len_dw == 11'd1) begin
      // Single DW: both ends come from be_first; all-zero BEs is a 1-byte zero-length read.
      if (i_be_first == 4'd0) begin
        o_fz_c    = 2'd0;
        o_total_c = 13'd1;
      end else begin
        o_total_c = 13'd4 - 13'(o_fz_c) - 13'(be_trail_zeros(i_be_first));
      end
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_read_cpl.sv
// Splits one inbound memory-read request into MPS-aligned completion headers.
// Optional DLSC_PCIE_S6_RCB_SPLIT_EN: first completion ends at the next RCB boundary (rcb_128 input).
module dlsc_pcie_s6_inbound_read_cpl
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int unsigned ADDR     = 32,
  parameter int unsigned MAX_SIZE = 128
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      max_payload_size,
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
  input  logic            rcb_128,
`endif
  output logic            req_ready,
  input  logic            req_valid,
  input  logic [ADDR-3:0] req_addr,
  input  logic [9:0]      req_len,
  input  logic [3:0]      req_be_first,
  input  logic [3:0]      req_be_last,
  input  logic [7:0]      req_tag,
  input  logic [15:0]     req_id,
  input  logic            cpl_h_ready,
  output logic            cpl_h_valid,
  output logic [ADDR-3:0] cpl_h_addr,
  output logic [9:0]      cpl_h_len,
  output logic [11:0]     cpl_h_byte_count,
  output logic [6:0]      cpl_h_lower_addr,
  output logic [7:0]      cpl_h_tag,
  output logic [15:0]     cpl_h_id,
  output logic            cpl_h_last
);

  localparam int unsigned AW          = ADDR - 2;
  localparam int unsigned MAX_SIZE_DW = MAX_SIZE / 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [10:0]   r_rem_dw;
  logic [12:0]   r_rem_bytes;
  logic [10:0]   r_max_len;
  logic [1:0]    r_fz;
  logic          r_first;
  logic [7:0]    r_tag;
  logic [15:0]   r_id;

  logic [12:0]   w_total;
  logic [1:0]    w_fz;
  logic [10:0]   w_off;
  logic [10:0]   w_room;
  logic [10:0]   w_chunk;
  logic [12:0]   w_cover;
  logic          w_last;
  logic          w_load;
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
  logic [10:0]   w_rcb;
`endif

  dlsc_pcie_s6_cpl_bytecount u_bytecount (
    .i_len      (req_len),
    .i_be_first (req_be_first),
    .i_be_last  (req_be_last),
    .o_total_c  (w_total),
    .o_fz_c     (w_fz)
  );

  assign w_load = !cpl_h_valid || cpl_h_ready;

  // Next completion size and the bytes it consumes from the running byte count.
  always_comb begin
    w_off  = 11'(r_addr) & (r_max_len - 11'd1);
    w_room = r_max_len - w_off;
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
    w_rcb  = rcb_128 ? 11'd32 : 11'd16;
    if (r_first) w_room = w_rcb - (11'(r_addr) & (w_rcb - 11'd1));
    else         w_room = r_max_len;
`endif
    w_chunk = (r_rem_dw < w_room) ? r_rem_dw : w_room;
    w_last  = (w_chunk == r_rem_dw);
    w_cover = {w_chunk, 2'b00};
    if (w_last)       w_cover = r_rem_bytes;
    else if (r_first) w_cover = {w_chunk, 2'b00} - 13'(r_fz);
  end

  // Request FSM, splitter state and output header register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_rem_dw         <= '0;
      r_rem_bytes      <= '0;
      r_max_len        <= '0;
      r_fz             <= '0;
      r_first          <= 1'b0;
      r_tag            <= '0;
      r_id             <= '0;
      req_ready        <= 1'b1;
      cpl_h_valid      <= 1'b0;
      cpl_h_addr       <= '0;
      cpl_h_len        <= '0;
      cpl_h_byte_count <= '0;
      cpl_h_lower_addr <= '0;
      cpl_h_tag        <= '0;
      cpl_h_id         <= '0;
      cpl_h_last       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_max_len <= mps_to_dw(max_payload_size, MAX_SIZE_DW);
          if (w_load) cpl_h_valid <= 1'b0;
          if (req_valid && req_ready) begin
            r_addr      <= req_addr;
            r_rem_dw    <= (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
            r_rem_bytes <= w_total;
            r_fz        <= w_fz;
            r_first     <= 1'b1;
            r_tag       <= req_tag;
            r_id        <= req_id;
            req_ready   <= 1'b0;
            r_state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_load) begin
            cpl_h_valid      <= 1'b1;
            cpl_h_addr       <= r_addr;
            cpl_h_len        <= 10'(w_chunk);
            cpl_h_byte_count <= r_rem_bytes[11:0];
            cpl_h_lower_addr <= {r_addr[4:0], (r_first ? r_fz : 2'b00)};
            cpl_h_tag        <= r_tag;
            cpl_h_id         <= r_id;
            cpl_h_last       <= w_last;
            r_addr           <= r_addr + AW'(w_chunk);
            r_rem_dw         <= r_rem_dw - w_chunk;
            r_rem_bytes      <= r_rem_bytes - w_cover;
            r_first          <= 1'b0;
            if (w_last) begin
              req_ready <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_cpl.sv
// Directed bench for the read-completion splitter (DUT built with MAX_SIZE=512).
module tb_dlsc_pcie_s6_inbound_read_cpl;

  localparam int unsigned ADDR = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      max_payload_size;
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
  logic            rcb_128;
`endif
  logic            req_ready;
  logic            req_valid;
  logic [ADDR-3:0] req_addr;
  logic [9:0]      req_len;
  logic [3:0]      req_be_first;
  logic [3:0]      req_be_last;
  logic [7:0]      req_tag;
  logic [15:0]     req_id;
  logic            cpl_h_ready;
  logic            cpl_h_valid;
  logic [ADDR-3:0] cpl_h_addr;
  logic [9:0]      cpl_h_len;
  logic [11:0]     cpl_h_byte_count;
  logic [6:0]      cpl_h_lower_addr;
  logic [7:0]      cpl_h_tag;
  logic [15:0]     cpl_h_id;
  logic            cpl_h_last;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_read_cpl #(.ADDR(ADDR), .MAX_SIZE(512)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .max_payload_size (max_payload_size),
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
    .rcb_128          (rcb_128),
`endif
    .req_ready        (req_ready),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_be_first     (req_be_first),
    .req_be_last      (req_be_last),
    .req_tag          (req_tag),
    .req_id           (req_id),
    .cpl_h_ready      (cpl_h_ready),
    .cpl_h_valid      (cpl_h_valid),
    .cpl_h_addr       (cpl_h_addr),
    .cpl_h_len        (cpl_h_len),
    .cpl_h_byte_count (cpl_h_byte_count),
    .cpl_h_lower_addr (cpl_h_lower_addr),
    .cpl_h_tag        (cpl_h_tag),
    .cpl_h_id         (cpl_h_id),
    .cpl_h_last       (cpl_h_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] byte_addr, input logic [9:0] len,
                          input logic [3:0] bef, input logic [3:0] bel,
                          input logic [7:0] tag, input logic [15:0] id,
                          input logic [2:0] mps);
    int t = 0;
    while (!req_ready && t < 200) begin
      tick();
      t++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_addr         = byte_addr[31:2];
    req_len          = len;
    req_be_first     = bef;
    req_be_last      = bel;
    req_tag          = tag;
    req_id           = id;
    max_payload_size = mps;
    req_valid        = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for a header, checks it, then lets it be consumed with cpl_h_ready=1.
  task automatic expect_hdr(input string name, input logic [31:0] byte_addr,
                            input logic [9:0] len, input logic [11:0] bc,
                            input logic [6:0] la, input logic last);
    int t = 0;
    while (!cpl_h_valid && t < 50) begin
      tick();
      t++;
    end
    check({name, ".valid"}, 32'(cpl_h_valid), 32'd1);
    check({name, ".addr"},  32'(cpl_h_addr), 32'(byte_addr[31:2]));
    check({name, ".len"},   32'(cpl_h_len), 32'(len));
    check({name, ".bc"},    32'(cpl_h_byte_count), 32'(bc));
    check({name, ".la"},    32'(cpl_h_lower_addr), 32'(la));
    check({name, ".last"},  32'(cpl_h_last), 32'(last));
    tick();
  endtask

  initial begin
    rst_n            = 1'b0;
    max_payload_size = 3'b000;
`ifdef DLSC_PCIE_S6_RCB_SPLIT_EN
    rcb_128          = 1'b0;
`endif
    req_valid        = 1'b0;
    req_addr         = '0;
    req_len          = '0;
    req_be_first     = '0;
    req_be_last      = '0;
    req_tag          = '0;
    req_id           = '0;
    cpl_h_ready      = 1'b1;

    // Reset state
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.valid",     32'(cpl_h_valid), 32'd0);
    check("rst.len",       32'(cpl_h_len), 32'd0);
    check("rst.bc",        32'(cpl_h_byte_count), 32'd0);
    check("rst.last",      32'(cpl_h_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single DW, full BEs; header not yet valid right after acceptance
    send_req(32'h1000, 10'd1, 4'hF, 4'h0, 8'h11, 16'hABCD, 3'b000);
    check("t1.latency_valid", 32'(cpl_h_valid), 32'd0);
    check("t1.req_ready",     32'(req_ready), 32'd0);
    tick();
    check("t1.tag", 32'(cpl_h_tag), 32'h11);
    check("t1.id",  32'(cpl_h_id), 32'hABCD);
    expect_hdr("t1", 32'h1000, 10'd1, 12'd4, 7'h00, 1'b1);
    check("t1.done_valid", 32'(cpl_h_valid), 32'd0);
    check("t1.done_ready", 32'(req_ready), 32'd1);

    // Unaligned 64 DW at 128B MPS: 31/32/1
    send_req(32'h2004, 10'd64, 4'hE, 4'h7, 8'h22, 16'h1234, 3'b000);
    expect_hdr("t2a", 32'h2004, 10'd31, 12'd254, 7'h05, 1'b0);
    check("t2.req_ready_mid", 32'(req_ready), 32'd0);
    expect_hdr("t2b", 32'h2080, 10'd32, 12'd131, 7'h00, 1'b0);
    expect_hdr("t2c", 32'h2100, 10'd1,  12'd3,   7'h00, 1'b1);
    check("t2.no_extra", 32'(cpl_h_valid), 32'd0);

    // 1024 DW at 4KB MPS capped to 512B: 8 x 128 DW
    send_req(32'h0000, 10'd0, 4'hF, 4'hF, 8'h33, 16'h0001, 3'b101);
    expect_hdr("t3_0", 32'h0000, 10'd128, 12'd0,    7'h00, 1'b0);
    expect_hdr("t3_1", 32'h0200, 10'd128, 12'd3584, 7'h00, 1'b0);
    expect_hdr("t3_2", 32'h0400, 10'd128, 12'd3072, 7'h00, 1'b0);
    expect_hdr("t3_3", 32'h0600, 10'd128, 12'd2560, 7'h00, 1'b0);
    expect_hdr("t3_4", 32'h0800, 10'd128, 12'd2048, 7'h00, 1'b0);
    expect_hdr("t3_5", 32'h0A00, 10'd128, 12'd1536, 7'h00, 1'b0);
    expect_hdr("t3_6", 32'h0C00, 10'd128, 12'd1024, 7'h00, 1'b0);
    expect_hdr("t3_7", 32'h0E00, 10'd128, 12'd512,  7'h00, 1'b1);
    check("t3.no_extra", 32'(cpl_h_valid), 32'd0);

    // Zero-length read
    send_req(32'h1234, 10'd1, 4'h0, 4'h0, 8'h44, 16'h0002, 3'b000);
    expect_hdr("t4", 32'h1234, 10'd1, 12'd1, 7'h34, 1'b1);

    // Back-pressure with a reserved MPS code (acts as 128B): 64 DW -> 32/32
    cpl_h_ready = 1'b0;
    send_req(32'h4000, 10'd64, 4'hF, 4'hF, 8'h55, 16'h0003, 3'b110);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5.hold_valid", 32'(cpl_h_valid), 32'd1);
      check("t5.hold_addr",  32'(cpl_h_addr), 32'(32'h4000 >> 2));
      check("t5.hold_bc",    32'(cpl_h_byte_count), 32'd256);
      check("t5.hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    cpl_h_ready = 1'b1;
    expect_hdr("t5a", 32'h4000, 10'd32, 12'd256, 7'h00, 1'b0);
    expect_hdr("t5b", 32'h4080, 10'd32, 12'd128, 7'h00, 1'b1);
    check("t5.no_extra", 32'(cpl_h_valid), 32'd0);

    // Reset while the 2nd of 4 headers is presented
    send_req(32'h5000, 10'd128, 4'hF, 4'hF, 8'h66, 16'h0004, 3'b000);
    expect_hdr("t6a", 32'h5000, 10'd32, 12'd512, 7'h00, 1'b0);
    check("t6.second_valid", 32'(cpl_h_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 32'(cpl_h_valid), 32'd0);
    check("t6.rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6.after_rst_valid", 32'(cpl_h_valid), 32'd0);
    send_req(32'h6000, 10'd2, 4'hF, 4'h3, 8'h77, 16'h0005, 3'b000);
    tick();
    check("t6.new_tag", 32'(cpl_h_tag), 32'h77);
    expect_hdr("t6n", 32'h6000, 10'd2, 12'd6, 7'h00, 1'b1);
    check("t6.no_extra", 32'(cpl_h_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
